// File: rtl/mdu.sv
// mdu: iterative MULT/DIV unit writing HI/LO, plus direct MTHI/MTLO; MDU_DIV_EN builds the divider.
// Latency: MULT/DIV results land WIDTH+1 edges after issue; MTHI/MTLO are visible the next cycle.
// Backpressure: busy stays high for the whole operation; start is ignored while busy.
module mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MDU_DIV_EN
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
`endif

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic               mt_hi;
    logic               mt_lo;

    logic [CNT_W-1:0]   cnt;
    // Upper half: multiply partial sum / running remainder.
    // Lower half: multiplier being shifted out / dividend shifting into quotient.
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    // Multiplicand magnitude for multiply, divisor magnitude for divide.
    logic [WIDTH-1:0]   addend;
    // Product / quotient needs negating at the end.
    logic               neg_res;

    logic               is_mul_op;
    logic               is_div_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fin_hi;
    logic [WIDTH-1:0]   fin_lo;

`ifdef MDU_DIV_EN
    logic               div_q;
    logic               neg_rem;
    logic               dz_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_step;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
`endif

    // ---------------------------------------------------------------
    // Issue decode and operand magnitudes
    // ---------------------------------------------------------------
    assign is_mul_op = (op == OP_MULTU) || (op == OP_MULT);
`ifdef MDU_DIV_EN
    assign is_div_op = (op == OP_DIVU) || (op == OP_DIV);
`else
    assign is_div_op = 1'b0;
`endif

    // The signed variants are the odd opcodes.
    assign a_neg = op[0] & a[WIDTH-1];
    assign b_neg = op[0] & b[WIDTH-1];
    // The most-negative value maps onto itself, which is its correct unsigned magnitude.
    assign mag_a = a_neg ? ({WIDTH{1'b0}} - a) : a;
    assign mag_b = b_neg ? ({WIDTH{1'b0}} - b) : b;

    // ---------------------------------------------------------------
    // One iteration of shift-add multiply / restoring divide
    // ---------------------------------------------------------------
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, addend} : {(WIDTH+1){1'b0}});
    assign mul_step = {mul_sum, acc[WIDTH-1:1]};

`ifdef MDU_DIV_EN
    // Remainder stays below the divisor, so a carry out of the shift always subtracts cleanly.
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, addend};
    assign div_step  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
    assign acc_step  = div_q ? div_step : mul_step;
`else
    assign acc_step  = mul_step;
`endif

    // ---------------------------------------------------------------
    // Sign correction and final HI/LO values presented during FIN
    // ---------------------------------------------------------------
    assign prod_fix = neg_res ? ({(2*WIDTH){1'b0}} - acc) : acc;
`ifdef MDU_DIV_EN
    // Most-negative / -1 needs no special case: the quotient magnitude is already
    // the most-negative pattern, signs agree so it is not negated, and remainder is 0.
    assign quo_fix  = neg_res ? ({WIDTH{1'b0}} - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    assign rem_fix  = neg_rem ? ({WIDTH{1'b0}} - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
`endif

    // Select the result that HI/LO take at the edge ending FIN.
    always_comb begin
        fin_hi = prod_fix[2*WIDTH-1:WIDTH];
        fin_lo = prod_fix[WIDTH-1:0];
`ifdef MDU_DIV_EN
        if (div_q) begin
            if (dz_q) begin
                fin_hi = a_q;
                fin_lo = {WIDTH{1'b1}};
            end else begin
                fin_hi = rem_fix;
                fin_lo = quo_fix;
            end
        end
`endif
    end

    // ---------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------
    // Next-state and issue decode; MT writes only happen from IDLE.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        mt_hi     = 1'b0;
        mt_lo     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (is_mul_op || is_div_op) begin
                        accept    = 1'b1;
                        state_nxt = RUN;
                    end
                    mt_hi = (op == OP_MTHI);
                    mt_lo = (op == OP_MTLO);
                end
            end
            RUN: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register with registered busy/done so both come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= (state == FIN);
        end
    end

    // Operand latch at issue, then one iteration per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            acc     <= '0;
            addend  <= '0;
            neg_res <= 1'b0;
`ifdef MDU_DIV_EN
            div_q   <= 1'b0;
            neg_rem <= 1'b0;
            dz_q    <= 1'b0;
            a_q     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt     <= '0;
                        neg_res <= a_neg ^ b_neg;
                        if (is_div_op) begin
                            addend <= mag_b;
                            acc    <= {{WIDTH{1'b0}}, mag_a};
                        end else begin
                            addend <= mag_a;
                            acc    <= {{WIDTH{1'b0}}, mag_b};
                        end
`ifdef MDU_DIV_EN
                        div_q   <= is_div_op;
                        neg_rem <= a_neg;
                        dz_q    <= (b == {WIDTH{1'b0}});
                        a_q     <= a;
`endif
                    end
                end
                RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    acc <= acc_step;
                end
                default: begin
                end
            endcase
        end
    end

    // Architectural HI/LO: direct moves from IDLE, results at the edge ending FIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (state == FIN) begin
            hi <= fin_hi;
            lo <= fin_lo;
        end else begin
            if (mt_hi) begin
                hi <= a;
            end
            if (mt_lo) begin
                lo <= a;
            end
        end
    end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed scoreboard bench for mdu at WIDTH=32; results checked by a done-driven monitor.
// Latency: monitor also checks that each result arrives WIDTH+1 edges after its issue edge.
// Backpressure: exercises ignored issues while busy and back-to-back issue in the done cycle.
module tb_mdu;

    localparam int W = 32;

    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op    = 3'b000;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    mdu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge: drives one issue across the next rising edge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input bit expect_res, input logic [W-1:0] ehi, input logic [W-1:0] elo);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = ia;
        b     = ib;
        if (expect_res) begin
            e.hi  = ehi;
            e.lo  = elo;
            e.due = cyc + W + 2;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_done: done not seen within 100 cycles (got 0, required 1)");
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest outstanding result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 with nothing pending, required 0");
            end else begin
                mon_e = sb.pop_front();
                chk("result_hi", hi, mon_e.hi);
                chk("result_lo", lo, mon_e.lo);
                chk("result_latency", cyc, mon_e.due);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // MULTU max*max with busy length, HI/LO hold and done width
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001);
        n = 0;
        while (busy && n < 100) begin
            if (n == 16) begin
                chk("hold_hi_in_run", hi, 0);
                chk("hold_lo_in_run", lo, 0);
            end
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", n, 33);
        chk("done_rise", done, 1);
        @(negedge clk);
        chk("done_width", done, 0);

        // Signed multiplies
        issue(OP_MULT, 32'hFFFFFFFD, 32'h00000005, 1, 32'hFFFFFFFF, 32'hFFFFFFF1);
        wait_done();
        issue(OP_MULT, 32'h80000000, 32'h80000000, 1, 32'h40000000, 32'h00000000);
        wait_done();
        @(negedge clk);

        // Issues while busy are ignored, MT included
        issue(OP_MULTU, 32'd2, 32'd3, 1, 32'd0, 32'd6);
        repeat (3) @(negedge clk);
        issue(OP_MTHI, 32'h12345678, 32'd0, 0, '0, '0);
        chk("busy_mthi_hi", hi, 32'h40000000);
        chk("busy_still", busy, 1);
        issue(OP_MULTU, 32'd9, 32'd9, 0, '0, '0);
        wait_done();

        // Direct moves after completion (issued in the done cycle)
        issue(OP_MTHI, 32'h12345678, 32'd0, 0, '0, '0);
        chk("mthi_hi", hi, 32'h12345678);
        chk("mthi_busy", busy, 0);
        issue(OP_MTLO, 32'hCAFEF00D, 32'd0, 0, '0, '0);
        chk("mtlo_lo", lo, 32'hCAFEF00D);
        chk("mtlo_hi_kept", hi, 32'h12345678);

`ifdef MDU_DIV_EN
        // Divides: signed, overflow, divide by zero, plain unsigned
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD);
        wait_done();
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000, 32'h80000000);
        wait_done();
        issue(OP_DIVU, 32'd7, 32'd0, 1, 32'd7, 32'hFFFFFFFF);
        wait_done();
        issue(OP_DIVU, 32'd100, 32'd7, 1, 32'd2, 32'd14);
        wait_done();
        issue(OP_DIV, 32'd7, 32'hFFFFFFFE, 1, 32'd1, 32'hFFFFFFFD);
        wait_done();
        issue(OP_DIV, 32'hFFFFFFF9, 32'd0, 1, 32'hFFFFFFF9, 32'hFFFFFFFF);
        wait_done();
        @(negedge clk);
`else
        // Divider absent: DIV/DIVU are no-ops
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 0, '0, '0);
        chk("nodiv_busy_div", busy, 0);
        issue(OP_DIVU, 32'd7, 32'd0, 0, '0, '0);
        chk("nodiv_busy_divu", busy, 0);
        repeat (40) @(negedge clk);
        chk("nodiv_hi", hi, 32'h12345678);
        chk("nodiv_lo", lo, 32'hCAFEF00D);
`endif

        // Back-to-back: second issue in the done cycle of the first
        issue(OP_MULTU, 32'h00010000, 32'h00010000, 1, 32'h00000001, 32'h00000000);
        wait_done();
        issue(OP_MULTU, 32'h0000FFFF, 32'h00010001, 1, 32'h00000000, 32'hFFFFFFFF);
        chk("b2b_busy", busy, 1);
        wait_done();
        @(negedge clk);

        // Reset mid-operation aborts without done
        issue(OP_MTHI, 32'hA5A5A5A5, 32'd0, 0, '0, '0);
        chk("pre_abort_hi", hi, 32'hA5A5A5A5);
`ifdef MDU_DIV_EN
        issue(OP_DIVU, 32'd1000, 32'd3, 0, '0, '0);
`else
        issue(OP_MULTU, 32'h55, 32'h77, 0, '0, '0);
`endif
        repeat (9) @(negedge clk);
        chk("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_abort_busy", busy, 0);
        chk("post_abort_lo", lo, 0);

        // Normal operation after the abort
        issue(OP_MULTU, 32'h00001234, 32'h00000100, 1, 32'h00000000, 32'h00123400);
        wait_done();
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
